// File: rtl/fpu_io_framer_if.sv
// Pin-side and core-side signal bundle of the FPU I/O framer.
// master = framer; slave = the surrounding pins/core (or a bench standing in for them).
interface fpu_io_framer_if;
  logic [11:0] io_in;
  logic [11:0] io_out;
  logic        core_valid;
  logic        core_ready;
  logic [3:0]  core_op;
  logic [15:0] core_a;
  logic [15:0] core_b;
  logic        core_done;
  logic [15:0] core_result;
  logic [4:0]  core_flags;

  modport master (
    input  io_in, core_ready, core_done, core_result, core_flags,
    output io_out, core_valid, core_op, core_a, core_b
  );

  modport slave (
    output io_in, core_ready, core_done, core_result, core_flags,
    input  io_out, core_valid, core_op, core_a, core_b
  );
endinterface

// File: rtl/fpu_io_framer.sv
// Tagged-byte pin framer for the half-precision FPU: builds operands/opcode, issues one core request,
// returns result as three tagged beats (first beat after the done edge); request held until accepted, pins ignored while busy.
module fpu_io_framer #(
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  fpu_io_framer_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT_HI, OUT_LO, OUT_ST} state_t;

  localparam logic [1:0] TAG_IDLE = 2'b00;
  localparam logic [1:0] TAG_A    = 2'b01;
  localparam logic [1:0] TAG_B    = 2'b10;
  localparam logic [1:0] TAG_CMD  = 2'b11;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] a_dat, b_dat;
  logic        a_lo, a_full, b_lo, b_full;
  logic [1:0]  prev_tag;
  logic [7:0]  wait_cnt;
  logic [7:0]  res_lo, status;

  logic [1:0]  in_tag;
  logic [7:0]  in_val;
  logic        take_beats;
  logic        cmd_vld;
  logic        unused_pins;

  assign in_tag      = bus.io_in[1:0];
  assign in_val      = bus.io_in[9:2];
  assign unused_pins = ^bus.io_in[11:10];

  // The edge that leaves OUT_ST already behaves as idle, so a new beat can land right after the status beat.
  assign take_beats = (state == IDLE) || (state == OUT_ST);
  assign cmd_vld    = take_beats && (in_tag == TAG_CMD) && (prev_tag != TAG_CMD);

  function automatic logic [11:0] beat(input logic [1:0] tag, input logic [7:0] val);
    return {1'b0, 1'b1, val, tag};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      a_dat          <= '0;
      b_dat          <= '0;
      a_lo           <= 1'b0;
      a_full         <= 1'b0;
      b_lo           <= 1'b0;
      b_full         <= 1'b0;
      prev_tag       <= TAG_CMD;
      wait_cnt       <= '0;
      res_lo         <= '0;
      status         <= '0;
      bus.io_out     <= '0;
      bus.core_valid <= 1'b0;
      bus.core_op    <= '0;
      bus.core_a     <= '0;
      bus.core_b     <= '0;
    end else begin
      prev_tag <= in_tag;

      if (take_beats) begin
        case (in_tag)
          TAG_A: begin
            if (a_lo) begin
              a_dat[7:0] <= in_val;
              a_full     <= 1'b1;
              a_lo       <= 1'b0;
            end else begin
              a_dat[15:8] <= in_val;
              a_full      <= 1'b0;
              a_lo        <= 1'b1;
            end
          end
          TAG_B: begin
            if (b_lo) begin
              b_dat[7:0] <= in_val;
              b_full     <= 1'b1;
              b_lo       <= 1'b0;
            end else begin
              b_dat[15:8] <= in_val;
              b_full      <= 1'b0;
              b_lo        <= 1'b1;
            end
          end
          TAG_CMD: begin
            if (prev_tag != TAG_CMD) begin
              a_lo <= 1'b0;
              b_lo <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      case (state)
        IDLE, OUT_ST: begin
          state      <= IDLE;
          bus.io_out <= '0;
          if (cmd_vld) begin
            if (a_full && b_full) begin
              state          <= ISSUE;
              bus.core_valid <= 1'b1;
              bus.core_op    <= in_val[3:0];
              bus.core_a     <= a_dat;
              bus.core_b     <= b_dat;
              bus.io_out     <= beat(TAG_IDLE, 8'h00);
            end else begin
              // Missing operand: answer with a quiet NaN instead of bothering the core.
              state      <= OUT_HI;
              res_lo     <= 8'h00;
              status     <= 8'h80;
              bus.io_out <= beat(TAG_A, 8'h7E);
            end
          end
        end
        ISSUE: begin
          if (bus.core_ready) begin
            bus.core_valid <= 1'b0;
            wait_cnt       <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (bus.core_done) begin
            res_lo     <= bus.core_result[7:0];
            status     <= {3'b000, bus.core_flags};
            bus.io_out <= beat(TAG_A, bus.core_result[15:8]);
            state      <= OUT_HI;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            res_lo     <= 8'h00;
            status     <= 8'h40;
            bus.io_out <= beat(TAG_A, 8'h7E);
            state      <= OUT_HI;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        OUT_HI: begin
          bus.io_out <= beat(TAG_B, res_lo);
          state      <= OUT_LO;
        end
        OUT_LO: begin
          bus.io_out <= beat(TAG_CMD, status);
          state      <= OUT_ST;
        end
        default: begin
          bus.io_out <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_io_framer.sv
// Bench for fpu_io_framer: an edge-timed transaction model of the pin protocol and core handshake is
// compared against the DUT every cycle; literal checks pin handshake contents and result beats.
module tb_fpu_io_framer;
  localparam int TB_TIMEOUT = 8;
  localparam int NEVER      = 1 << 30;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fpu_io_framer_if bus();
  fpu_io_framer #(.TIMEOUT(TB_TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0] tag;
    logic [7:0] val;
    int         at;
  } beat_t;

  typedef struct packed {
    logic [15:0] v;
    logic        lo;
    logic        full;
  } opnd_t;

  beat_t exp_beats[$];

  // Core behaviour chosen by the stimulus; cfg_lat <= 0 means the core never answers.
  int          cfg_lat  = 3;
  logic [15:0] cfg_res  = 16'h0000;
  logic [4:0]  cfg_flg  = 5'h00;
  int          stray_at = NEVER;

  opnd_t       ma, mb;
  logic [1:0]  m_prev;
  bit          req_pending;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  int          busy_from = NEVER;
  int          free_edge = 0;
  int          done_edge = -1;
  int          hs_count  = 0;
  logic [3:0]  hs_op;
  logic [15:0] hs_a, hs_b;
  logic [9:0]  lb [3];

  function automatic opnd_t load(input opnd_t o, input logic [7:0] b);
    opnd_t r = o;
    if (!o.lo) begin
      r.v    = {b, o.v[7:0]};
      r.full = 1'b0;
      r.lo   = 1'b1;
    end else begin
      r.v    = {o.v[15:8], b};
      r.full = 1'b1;
      r.lo   = 1'b0;
    end
    return r;
  endfunction

  task automatic push_result(input int at, input logic [15:0] res, input logic [7:0] st);
    beat_t b;
    b.tag = 2'b01; b.val = res[15:8]; b.at = at;     exp_beats.push_back(b);
    b.tag = 2'b10; b.val = res[7:0];  b.at = at + 1; exp_beats.push_back(b);
    b.tag = 2'b11; b.val = st;        b.at = at + 2; exp_beats.push_back(b);
    free_edge = at + 3;
  endtask

  // Model + compare: outputs seen now belong to edge cyc; inputs seen now are sampled at edge cyc+1.
  initial begin
    int    e;
    beat_t eb;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    bus.core_flags  = '0;
    for (int i = 0; i < 3; i++) lb[i] = '0;
    forever begin
      @(negedge clock);
      e = cyc + 1;
      if (!reset) begin
        exp_beats.delete();
        ma = '0; mb = '0; m_prev = 2'b11;
        req_pending = 0; busy_from = NEVER; free_edge = 0; done_edge = -1;
        bus.core_done = 1'b0;
      end else begin
        if (bus.io_out[1:0] != 2'b00) begin
          if (exp_beats.size() == 0) begin
            check("beat_unexpected", 32'(bus.io_out[9:0]), 32'd0);
          end else begin
            eb = exp_beats.pop_front();
            check("beat_tag", 32'(bus.io_out[1:0]), 32'(eb.tag));
            check("beat_val", 32'(bus.io_out[9:2]), 32'(eb.val));
            check("beat_cycle", 32'(cyc), 32'(eb.at));
          end
          lb[0] = lb[1]; lb[1] = lb[2]; lb[2] = bus.io_out[9:0];
        end
        check("busy", 32'(bus.io_out[10]), 32'(cyc >= busy_from && cyc < free_edge));
        check("io_out_bit11", 32'(bus.io_out[11]), 32'd0);
        check("core_valid", 32'(bus.core_valid), 32'(req_pending));
        if (req_pending && bus.core_valid) begin
          check("core_op", 32'(bus.core_op), 32'(req_op));
          check("core_a", 32'(bus.core_a), 32'(req_a));
          check("core_b", 32'(bus.core_b), 32'(req_b));
        end

        if (bus.core_valid && bus.core_ready) begin
          hs_count++;
          hs_op = bus.core_op; hs_a = bus.core_a; hs_b = bus.core_b;
          if (req_pending) begin
            req_pending = 0;
            if (cfg_lat > 0) begin
              done_edge = e + cfg_lat;
              push_result(done_edge, cfg_res, {3'b000, cfg_flg});
            end else begin
              done_edge = -1;
              push_result(e + TB_TIMEOUT, 16'h7E00, 8'h40);
            end
          end
        end
        bus.core_done   = (e == done_edge) || (e == stray_at);
        bus.core_result = (e == done_edge) ? cfg_res : 16'hBEEF;
        bus.core_flags  = (e == done_edge) ? cfg_flg : 5'h1F;

        if (e >= free_edge) begin
          case (bus.io_in[1:0])
            2'b01: ma = load(ma, bus.io_in[9:2]);
            2'b10: mb = load(mb, bus.io_in[9:2]);
            2'b11: begin
              if (m_prev != 2'b11) begin
                ma.lo = 1'b0; mb.lo = 1'b0;
                busy_from = e;
                if (ma.full && mb.full) begin
                  req_pending = 1;
                  req_op = bus.io_in[5:2]; req_a = ma.v; req_b = mb.v;
                  free_edge = NEVER;
                end else begin
                  push_result(e, 16'h7E00, 8'h80);
                end
              end
            end
            default: ;
          endcase
        end
        m_prev = bus.io_in[1:0];
      end
    end
  end

  task automatic drive(input logic [1:0] tag, input logic [7:0] val);
    @(posedge clock);
    #1;
    bus.io_in = {2'b00, val, tag};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 8'h00);
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = (exp_beats.size() == 0) && !req_pending && (cyc >= free_edge) &&
           (bus.io_out == 12'h000) && !bus.core_valid;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic check_last3(input string name, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] st);
    check({name, "_hi"}, 32'(lb[0]), 32'({hi, 2'b01}));
    check({name, "_lo"}, 32'(lb[1]), 32'({lo, 2'b10}));
    check({name, "_st"}, 32'(lb[2]), 32'({st, 2'b11}));
  endtask

  initial begin
    int hs0;
    bus.io_in      = {2'b00, 8'h00, 2'b11};
    bus.core_ready = 1'b1;

    // Reset values, with the command tag already held high.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_io_out", 32'(bus.io_out), 32'h0);
    check("rst_core_valid", 32'(bus.core_valid), 32'h0);
    check("rst_core_op", 32'(bus.core_op), 32'h0);
    check("rst_core_a", 32'(bus.core_a), 32'h0);
    check("rst_core_b", 32'(bus.core_b), 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (4) @(posedge clock);
    idle(3);
    check("held_thru_reset_hs", 32'(hs_count), 32'd0);
    check("held_thru_reset_out", 32'(bus.io_out), 32'h0);

    // Normal issue.
    cfg_lat = 3; cfg_res = 16'h0000; cfg_flg = 5'h00; hs0 = hs_count;
    drive(2'b01, 8'h4E); drive(2'b01, 8'h54);
    drive(2'b10, 8'h4E); drive(2'b10, 8'h54);
    drive(2'b11, 8'h02); idle(1);
    drain("normal_drain");
    check("normal_hs", 32'(hs_count - hs0), 32'd1);
    check("normal_a", 32'(hs_a), 32'h4E54);
    check("normal_b", 32'(hs_b), 32'h4E54);
    check("normal_op", 32'(hs_op), 32'h2);
    check_last3("normal", 8'h00, 8'h00, 8'h00);

    // Held command tag.
    cfg_lat = 2; cfg_res = 16'h4400; cfg_flg = 5'h00; hs0 = hs_count;
    drive(2'b01, 8'h3C); drive(2'b01, 8'h00);
    drive(2'b10, 8'h40); drive(2'b10, 8'h00);
    repeat (6) drive(2'b11, 8'h03);
    idle(1);
    drain("held_drain");
    check("held_hs", 32'(hs_count - hs0), 32'd1);
    check("held_a", 32'(hs_a), 32'h3C00);
    check("held_b", 32'(hs_b), 32'h4000);
    check("held_op", 32'(hs_op), 32'h3);
    check_last3("held", 8'h44, 8'h00, 8'h00);

    // Protocol errors: half-loaded B, then A only.
    hs0 = hs_count;
    drive(2'b10, 8'h11); drive(2'b11, 8'h05); idle(1);
    drain("perr1_drain");
    check_last3("perr1", 8'h7E, 8'h00, 8'h80);
    drive(2'b01, 8'h4E); drive(2'b01, 8'h54);
    drive(2'b11, 8'h01); idle(1);
    drain("perr2_drain");
    check_last3("perr2", 8'h7E, 8'h00, 8'h80);
    check("perr_hs", 32'(hs_count - hs0), 32'd0);

    // Timeout, then a stray done pulse while idle.
    cfg_lat = -1; hs0 = hs_count;
    drive(2'b10, 8'h4E); drive(2'b10, 8'h54);
    drive(2'b11, 8'h04); idle(1);
    drain("timeout_drain");
    check("timeout_hs", 32'(hs_count - hs0), 32'd1);
    check("timeout_op", 32'(hs_op), 32'h4);
    check_last3("timeout", 8'h7E, 8'h00, 8'h40);
    stray_at = cyc + 3;
    idle(8);
    stray_at = NEVER;
    check("stray_done_out", 32'(bus.io_out), 32'h0);
    check("stray_done_hs", 32'(hs_count - hs0), 32'd1);

    // Backpressure with operand beats arriving while busy.
    bus.core_ready = 1'b0;
    cfg_lat = 2; cfg_res = 16'h3C00; cfg_flg = 5'h01; hs0 = hs_count;
    drive(2'b11, 8'h06);
    drive(2'b01, 8'h11); drive(2'b01, 8'h22);
    drive(2'b10, 8'h33); drive(2'b10, 8'h44);
    idle(2);
    bus.core_ready = 1'b1;
    drain("bp_drain");
    check("bp_hs", 32'(hs_count - hs0), 32'd1);
    check("bp_op", 32'(hs_op), 32'h6);
    check_last3("bp", 8'h3C, 8'h00, 8'h01);
    drive(2'b11, 8'h07); idle(1);
    drain("bp_reuse_drain");
    check("bp_reuse_a", 32'(hs_a), 32'h4E54);
    check("bp_reuse_b", 32'(hs_b), 32'h4E54);
    check("bp_reuse_op", 32'(hs_op), 32'h7);

    // Reset in the middle of WAIT.
    cfg_lat = -1; hs0 = hs_count;
    drive(2'b11, 8'h02); idle(4);
    check("wait_busy", 32'(bus.io_out[10]), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_io_out", 32'(bus.io_out), 32'h0);
    check("mid_rst_valid", 32'(bus.core_valid), 32'h0);
    idle(2);
    @(posedge clock);
    #1 reset = 1'b1;
    idle(12);
    check("post_rst_quiet", 32'(bus.io_out), 32'h0);
    drive(2'b11, 8'h01); idle(1);
    drain("post_rst_drain");
    check_last3("post_rst", 8'h7E, 8'h00, 8'h80);
    check("post_rst_hs", 32'(hs_count - hs0), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/fpu_io_framer.md
# fpu_io_framer

Byte-level I/O framing stage for the 16-bit half-precision FPU. It sits between the chip's 12-bit tagged pin bus and the FPU arithmetic core. On the input side it assembles tagged byte beats into two 16-bit operands and an opcode, then issues one request to the core. On the output side it captures the core result and serializes it back onto the pins as three tagged byte beats.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles before the request is abandoned (1..255).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in  input  12  [1:0] in_tag, [9:2] in_val, [11:10] ignored.
- io_out  output  12  [1:0] out_tag, [9:2] out_val, [10] busy, [11] constant 0.
- core_valid  output  1  request to core; held until accepted.
- core_ready  input  1  core accepts the request when core_valid && core_ready.
- core_op  output  4  opcode; stable while core_valid.
- core_a, core_b  output  16  operands; stable while core_valid.
- core_done  input  1  one-cycle pulse; result and flags are valid.
- core_result  input  16  half-precision result.
- core_flags  input  5  {invalid, divzero, overflow, underflow, inexact}.

## Operation
- Input tags: 00 idle; 01 operand A byte; 10 operand B byte; 11 command (in_val[3:0] = opcode, in_val[7:4] ignored).
- Inputs are sampled every rising edge. In IDLE, each cycle with a nonzero tag is one beat. In any other state, all beats are ignored.
- Operand assembly:
  - Each operand has a half toggle (hi/lo) and a full flag.
  - A beat with toggle=0 loads [15:8], clears full, and sets toggle=1.
  - A beat with toggle=1 loads [7:0], sets full, and clears toggle.
  - Example: A = 0x4E then 0x54 gives 0x4E54.
  - Operands persist after a command and can be reused.
- Command acceptance:
  - A command is accepted only when prev_tag != 11. prev_tag is a register holding the last cycle's in_tag; it resets to 11.
  - As a result, a tag held at 11 over many cycles issues exactly one command.
  - Accepting a command clears both toggles.
- Command handling:
  - If A and B are both full: go to ISSUE.
  - Otherwise it is a protocol error: go directly to OUT_HI with result 0x7E00 and status 0x80.
- State machine: IDLE -> ISSUE -> WAIT -> OUT_HI -> OUT_LO -> OUT_ST -> IDLE.
  - ISSUE: core_valid=1. Leave ISSUE on handshake.
  - WAIT: a cycle counter starts at 0.
    - On core_done, register result and status, then go to OUT_HI.
    - If the counter reaches TIMEOUT with no core_done, use result 0x7E00 and status 0x40, then go to OUT_HI.
    - A core_done arriving outside WAIT is ignored.
  - OUT_HI drives tag 01 with result[15:8]. OUT_LO drives tag 10 with result[7:0]. OUT_ST drives tag 11 with status. Each lasts one cycle.
- Status byte: [7] protocol error, [6] timeout, [5] 0, [4:0] core_flags.
- busy = 1 in every state except IDLE.

## Timing
- All io_out bits and core_* outputs are registered.
- Reset values:
  - io_out = 0 and core_valid = 0.
  - core_op, core_a and core_b = 0.
  - Toggles and full flags = 0, prev_tag = 11, state = IDLE.
- Asserting reset in any state returns to IDLE immediately. An outstanding core request is dropped; no output beats follow.
- Command sampled at edge k: core_valid is high after edge k. If core_ready is high in that cycle, WAIT begins after edge k+1.
- core_done sampled at edge d: the OUT_HI beat is visible after edge d, the OUT_LO beat after d+1, and the OUT_ST beat after d+2. io_out tag returns to 00 and busy to 0 after d+3.
- Protocol error at edge k: beats appear after k, k+1 and k+2.
- Fastest path: the first post-idle input beat can be accepted at edge d+3.
- Timeout: a WAIT cycle count of exactly TIMEOUT with no core_done takes the timeout path. core_done on the same edge as the timeout wins.
- Operand beats that arrive in the same cycle a command is rejected or ignored (non-IDLE) are lost.

## Test plan
- Normal issue: A = 4E, 54 (tag 01); B = 4E, 54 (tag 10); command 0x02. Model core: ready=1, done 3 cycles later with result 0x0000, flags 0.
  - Required: core_a = core_b = 0x4E54 and core_op = 2, with exactly one core_valid handshake.
  - Required: out beats (01,0x00), (10,0x00), (11,0x00) on consecutive cycles, then tag 00 and busy 0.
- Held command: in_tag held at 11 for 6 cycles after loading both operands -> exactly one handshake. A tag held at 11 through reset release issues nothing.
- Protocol error: load A only (4E, 54), then command 0x01 -> core_valid never rises; beats (01,0x7E), (10,0x00), (11,0x80).
- Timeout: TIMEOUT=8, core never pulses done -> after 8 WAIT cycles, beats (01,0x7E), (10,0x00), (11,0x40). A later core_done pulse in IDLE is ignored.
- Busy/backpressure: core_ready low for 5 cycles -> core_valid, core_op and core_a stay stable. Operand beats sent while busy do not change core_a or core_b for the next command.
- Reset mid-WAIT: assert reset during WAIT -> io_out = 0 and core_valid = 0 immediately. After release, the first command with no new operands gives a protocol error (0x80).
